port_rd_backend: RTL and testbench
==================================

# port_rd_backend

Per-output-port read engine for the hydra switch, the egress counterpart of `port_wr_frontend`. It arbitrates among the port's 8 priority queues (strict priority or WRR), pops one packet at a time from the SRAM read path, and drives the `rd_sop`/`rd_vld`/`rd_data`/`rd_eop` egress protocol gated by `ready`. One instance per port (16 in `hydra`).

## Interface
- `NUM_PRIOR`, 8: number of priority queues; queue 7 is highest.
- `WORD_W`, 16: data word width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wrr_en`  in  1  1 = WRR scheduling, 0 = strict priority; this port's bit of `hydra.wrr_en`.
- `queue_nempty`  in  8  bit q = queue q holds at least one complete packet.
- `ready`  in  1  downstream may accept a new packet.
- `pop_vld`  out  1  one-cycle request to read the head packet of queue `pop_prior`.
- `pop_prior`  out  3  queue index for `pop_vld`.
- `fetch_vld`  in  1  SRAM read path delivers a word.
- `fetch_data`  in  16  packet word; first word is the header.
- `fetch_last`  in  1  qualifies the final word of the packet (with `fetch_vld`).
- `rd_sop`  out  1  start-of-packet pulse.
- `rd_vld`  out  1  `rd_data` valid.
- `rd_data`  out  16  egress word.
- `rd_eop`  out  1  end-of-packet pulse.
- `len_err`  out  1  one-cycle pulse: received word count disagrees with header length.

## Operation
- Header word: `[3:0]` dest port, `[6:4]` priority, `[15:7]` length L = number of data words after the header; packet is L+1 words.
- FSM states: IDLE, POP, DATA, EOP.
  - IDLE: if `ready` && `|queue_nempty`, arbiter selects q, registers it; -> POP.
  - POP (1 cycle): `pop_vld`=1, `pop_prior`=q, `rd_sop`=1; -> DATA.
  - DATA: each `fetch_vld` word is registered to `rd_data` with `rd_vld`=1 next cycle; gaps in `fetch_vld` give gaps in `rd_vld`. Word counter (10 bit) increments per word; L captured from first word. On `fetch_vld && fetch_last` -> EOP.
  - EOP (1 cycle): `rd_eop`=1; `len_err`=1 if count != L+1; -> IDLE.
- `ready` is sampled only in IDLE; once POP is entered the packet completes regardless of `ready`.
- Strict mode: select highest q with `queue_nempty[q]`.
- WRR mode: 4-bit credit per queue, full value q+1. Select highest nonempty q with credit > 0, decrement its credit. If no nonempty queue has credit, reload all credits to full in the same cycle and select highest nonempty queue (its reloaded credit decremented).
- While `wrr_en`=0 credits are held at full; mode change takes effect at next IDLE selection.
- Words arriving with `fetch_vld` in IDLE/POP/EOP are dropped (protocol violation, not flagged).

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0, credits full. Reset mid-packet aborts it; no `rd_eop` is emitted.
- Selection latency: `ready` and `nempty` seen high at edge N -> POP (`pop_vld`, `rd_sop`) in cycle N+1.
- Data latency: `fetch_vld` in cycle M -> `rd_vld`/`rd_data` in cycle M+1.
- Last word: `fetch_last` in cycle M -> last `rd_vld` in M+1, `rd_eop` in M+1 (EOP state concurrent with registered last word), back in IDLE at M+2; earliest next `rd_sop` at M+3.
- `rd_sop` and the first `rd_vld` are never in the same cycle; `rd_eop` coincides with the last `rd_vld`.
- Queue manager must drop `queue_nempty[q]` by the cycle after POP if it popped the last packet; the backend does not re-arbitrate before IDLE.
- Counter saturates at 1023; longer packets flag `len_err`.

## Structure
- Shared `hydra_pkg`: `NUM_PRIOR`, header field LSB/MSB constants, FSM state enum, WRR weight function (q+1).
- One sub-module `rd_wrr_arbiter`: credits, reload, strict/WRR select; outputs `grant_vld`, `grant_q`, driven by `grant_take` from the FSM.

## Test plan
- Strict: `nempty`=8'b1000_0101, `ready`=1 -> pops in order q7, q2, q0 as bits clear.
- WRR: all queues always nonempty, 36 packets -> q7 granted 8, q6 7, ... q0 1 per round; round repeats exactly.
- Packet L=3, fetch contiguous: `rd_sop` at N+1, 4 `rd_vld` words matching input, `rd_eop` with 4th word, no `len_err`.
- `fetch_vld` gaps and `ready` dropping mid-packet -> packet completes, `rd_vld` follows gaps by 1 cycle, no new `rd_sop` until `ready` high in IDLE.
- Header L=5 but `fetch_last` on 4th word -> `len_err` pulse with `rd_eop`.
- `rst_n`=0 in DATA -> next cycle all outputs 0, IDLE, credits full; new packet proceeds normally.

Source files
------------

// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared constants, FSM states and WRR weight for the hydra read path
package hydra_pkg;

  localparam int NUM_PRIOR   = 8;
  localparam int WORD_W      = 16;
  localparam int CNT_W       = 10;
  localparam int HDR_LEN_LSB = 7;
  localparam int HDR_LEN_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } rd_state_e;

  // Full credit value of a queue: higher queues get proportionally more turns.
  function automatic logic [3:0] wrr_weight(input logic [2:0] q);
    return {1'b0, q} + 4'd1;
  endfunction

endpackage

// File: rtl/rd_wrr_arbiter.sv
// rtl/rd_wrr_arbiter.sv - strict-priority / weighted-round-robin queue selector
module rd_wrr_arbiter
  import hydra_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrr_en,
  input  logic [NUM_PRIOR-1:0] queue_nempty,
  input  logic                 grant_take,
  output logic                 grant_vld,
  output logic [2:0]           grant_q
);

  logic [3:0]           credit [NUM_PRIOR];
  logic [NUM_PRIOR-1:0] eligible;
  logic                 hit;
  logic [2:0]           hit_q;
  logic [2:0]           any_q;

  // Queues that are nonempty and still hold credit in this round.
  always_comb begin
    eligible = '0;
    for (int q = 0; q < NUM_PRIOR; q++) begin
      eligible[q] = queue_nempty[q] && (credit[q] != 4'd0);
    end
  end

  // Highest-index encoders; ascending scan so the last match wins.
  always_comb begin
    hit   = 1'b0;
    hit_q = 3'd0;
    any_q = 3'd0;
    for (int q = 0; q < NUM_PRIOR; q++) begin
      if (eligible[q]) begin
        hit   = 1'b1;
        hit_q = 3'(q);
      end
      if (queue_nempty[q]) begin
        any_q = 3'(q);
      end
    end
  end

  assign grant_vld = |queue_nempty;
  assign grant_q   = (wrr_en && hit) ? hit_q : any_q;

  // Credits: held full in strict mode; spend on grant, reload when nobody eligible has any.
  always_ff @(posedge clk) begin
    if (!rst_n || !wrr_en) begin
      for (int q = 0; q < NUM_PRIOR; q++) begin
        credit[q] <= wrr_weight(3'(q));
      end
    end else if (grant_take && grant_vld) begin
      if (hit) begin
        credit[hit_q] <= credit[hit_q] - 4'd1;
      end else begin
        for (int q = 0; q < NUM_PRIOR; q++) begin
          credit[q] <= (3'(q) == any_q) ? wrr_weight(3'(q)) - 4'd1 : wrr_weight(3'(q));
        end
      end
    end
  end

endmodule

// File: rtl/port_rd_backend.sv
// rtl/port_rd_backend.sv - per-port egress read engine: arbitrate, pop, stream one packet
module port_rd_backend
  import hydra_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrr_en,
  input  logic [NUM_PRIOR-1:0] queue_nempty,
  input  logic                 ready,
  output logic                 pop_vld,
  output logic [2:0]           pop_prior,
  input  logic                 fetch_vld,
  input  logic [WORD_W-1:0]    fetch_data,
  input  logic                 fetch_last,
  output logic                 rd_sop,
  output logic                 rd_vld,
  output logic [WORD_W-1:0]    rd_data,
  output logic                 rd_eop,
  output logic                 len_err
);

  rd_state_e                           state_q, state_d;
  logic [2:0]                          q_sel;
  logic [CNT_W-1:0]                    cnt;
  logic [HDR_LEN_MSB-HDR_LEN_LSB:0]    len_q;
  logic                                rd_vld_q;
  logic [WORD_W-1:0]                   rd_data_q;
  logic                                grant_vld;
  logic [2:0]                          grant_q;
  logic                                grant_take;
  logic                                word_take;

  rd_wrr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrr_en       (wrr_en),
    .queue_nempty (queue_nempty),
    .grant_take   (grant_take),
    .grant_vld    (grant_vld),
    .grant_q      (grant_q)
  );

  assign word_take = (state_q == ST_DATA) && fetch_vld;

  // Next state and state-decoded pulses; ready only matters while idle.
  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    pop_vld    = 1'b0;
    rd_sop     = 1'b0;
    rd_eop     = 1'b0;
    len_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready && grant_vld) begin
          grant_take = 1'b1;
          state_d    = ST_POP;
        end
      end
      ST_POP: begin
        pop_vld = 1'b1;
        rd_sop  = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fetch_vld && fetch_last) begin
          state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        rd_eop  = 1'b1;
        len_err = (cnt != ({1'b0, len_q} + 10'd1));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop_prior = q_sel;
  assign rd_vld    = rd_vld_q;
  assign rd_data   = rd_data_q;

  // State, selected queue, word counter with saturation, header length and egress word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      q_sel     <= 3'd0;
      cnt       <= '0;
      len_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= word_take;
      if (grant_take) begin
        q_sel <= grant_q;
      end
      if (state_q == ST_POP) begin
        cnt <= '0;
      end else if (word_take) begin
        rd_data_q <= fetch_data;
        if (cnt == '0) begin
          len_q <= fetch_data[HDR_LEN_MSB:HDR_LEN_LSB];
        end
        if (cnt != {CNT_W{1'b1}}) begin
          cnt <= cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_port_rd_backend.sv
// tb/tb_port_rd_backend.sv - self-checking bench for port_rd_backend
module tb_port_rd_backend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrr_en;
  logic [7:0]  queue_nempty;
  logic        ready;
  logic        pop_vld;
  logic [2:0]  pop_prior;
  logic        fetch_vld;
  logic [15:0] fetch_data;
  logic        fetch_last;
  logic        rd_sop;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        rd_eop;
  logic        len_err;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb [$];

  port_rd_backend dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrr_en       (wrr_en),
    .queue_nempty (queue_nempty),
    .ready        (ready),
    .pop_vld      (pop_vld),
    .pop_prior    (pop_prior),
    .fetch_vld    (fetch_vld),
    .fetch_data   (fetch_data),
    .fetch_last   (fetch_last),
    .rd_sop       (rd_sop),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .rd_eop       (rd_eop),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a pop, check it, then stream nwords words and check the egress side.
  task automatic run_pkt(input logic [2:0] exp_q, input logic [8:0] len, input int nwords,
                         input logic [7:0] nempty_after, input bit gaps, input bit drop_ready,
                         input bit exp_lerr, output int nwait);
    logic [15:0] w;
    logic [15:0] exp_w;
    bit          got;
    got   = 0;
    nwait = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      nwait++;
      if (pop_vld) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL pop_timeout: no pop_vld within 40 cycles, expected queue %0d", exp_q);
      return;
    end
    checks++;
    if (pop_prior !== exp_q) begin
      failures++;
      $display("FAIL pop_prior: got %0d expected %0d", pop_prior, exp_q);
    end
    checks++;
    if (rd_sop !== 1'b1 || rd_vld !== 1'b0) begin
      failures++;
      $display("FAIL pop_cycle: rd_sop=%b rd_vld=%b expected 1 0", rd_sop, rd_vld);
    end
    queue_nempty = nempty_after;
    if (drop_ready) ready = 1'b0;
    tick();
    checks++;
    if (rd_vld !== 1'b0 || rd_sop !== 1'b0 || pop_vld !== 1'b0) begin
      failures++;
      $display("FAIL data_entry: rd_vld=%b rd_sop=%b pop_vld=%b expected 0 0 0", rd_vld, rd_sop, pop_vld);
    end
    for (int i = 0; i < nwords; i++) begin
      if (gaps && (i % 2 == 1)) begin
        fetch_vld = 1'b0;
        tick();
        checks++;
        if (rd_vld !== 1'b0) begin
          failures++;
          $display("FAIL gap: rd_vld=%b expected 0 at word %0d", rd_vld, i);
        end
      end
      w          = (i == 0) ? {len, exp_q, 4'h5} : 16'($urandom);
      fetch_vld  = 1'b1;
      fetch_data = w;
      fetch_last = (i == nwords - 1);
      sb.push_back(w);
      tick();
      fetch_vld  = 1'b0;
      fetch_last = 1'b0;
      checks++;
      if (rd_vld !== 1'b1 || rd_sop !== 1'b0) begin
        failures++;
        $display("FAIL word_vld: rd_vld=%b rd_sop=%b expected 1 0 at word %0d", rd_vld, rd_sop, i);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: rd_vld with empty queue at word %0d", i);
      end else begin
        exp_w = sb.pop_front();
        if (rd_data !== exp_w) begin
          failures++;
          $display("FAIL word_data: got %h expected %h at word %0d", rd_data, exp_w, i);
        end
      end
      checks++;
      if (rd_eop !== (i == nwords - 1)) begin
        failures++;
        $display("FAIL rd_eop: got %b expected %b at word %0d", rd_eop, (i == nwords - 1), i);
      end
      if (i == nwords - 1) begin
        checks++;
        if (len_err !== exp_lerr) begin
          failures++;
          $display("FAIL len_err: got %b expected %b", len_err, exp_lerr);
        end
      end
    end
    tick();
    checks++;
    if (rd_vld !== 1'b0 || rd_eop !== 1'b0 || len_err !== 1'b0 || rd_sop !== 1'b0) begin
      failures++;
      $display("FAIL post_eop: rd_vld=%b rd_eop=%b len_err=%b rd_sop=%b expected all 0",
               rd_vld, rd_eop, len_err, rd_sop);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({pop_vld, pop_prior, rd_sop, rd_vld, rd_data, rd_eop, len_err} !== '0) begin
      failures++;
      $display("FAIL %s: pop_vld=%b pop_prior=%0d rd_sop=%b rd_vld=%b rd_data=%h rd_eop=%b len_err=%b expected all 0",
               name, pop_vld, pop_prior, rd_sop, rd_vld, rd_data, rd_eop, len_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wrr_en = 1'b0; queue_nempty = 8'h00; ready = 1'b0;
    fetch_vld = 1'b0; fetch_data = 16'h0; fetch_last = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    tick();
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_strict();
    int nw;
    wrr_en = 1'b0; ready = 1'b1; queue_nempty = 8'b1000_0101;
    run_pkt(3'd7, 9'd1, 2, 8'b0000_0101, 0, 0, 0, nw);
    run_pkt(3'd2, 9'd0, 1, 8'b0000_0001, 0, 0, 0, nw);
    run_pkt(3'd0, 9'd2, 3, 8'b0000_0000, 0, 0, 0, nw);
  endtask

  task automatic test_single_packet();
    int nw;
    ready = 1'b0; queue_nempty = 8'h10;
    tick(); tick();
    checks++;
    if (pop_vld !== 1'b0 || rd_sop !== 1'b0) begin
      failures++;
      $display("FAIL ready_low_hold: pop_vld=%b rd_sop=%b expected 0 0", pop_vld, rd_sop);
    end
    ready = 1'b1;
    run_pkt(3'd4, 9'd3, 4, 8'h00, 0, 0, 0, nw);
    checks++;
    if (nw != 1) begin
      failures++;
      $display("FAIL select_latency: pop after %0d cycles expected 1", nw);
    end
  endtask

  task automatic test_gaps_ready_drop();
    int nw;
    ready = 1'b1; queue_nempty = 8'h08;
    run_pkt(3'd3, 9'd3, 4, 8'h08, 1, 1, 0, nw);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rd_sop !== 1'b0 || pop_vld !== 1'b0) begin
        failures++;
        $display("FAIL no_sop_ready_low: rd_sop=%b pop_vld=%b expected 0 0", rd_sop, pop_vld);
      end
    end
    ready = 1'b1;
    run_pkt(3'd3, 9'd1, 2, 8'h00, 0, 0, 0, nw);
  endtask

  task automatic test_len_err();
    int nw;
    ready = 1'b1; queue_nempty = 8'h40;
    run_pkt(3'd6, 9'd5, 4, 8'h00, 0, 0, 1, nw);
  endtask

  task automatic test_wrr();
    int       nw;
    logic [2:0] exp_seq [$];
    for (int r = 0; r < 2; r++)
      for (int q = 7; q >= 0; q--)
        for (int k = 0; k <= q; k++) exp_seq.push_back(3'(q));
    wrr_en = 1'b1; ready = 1'b1; queue_nempty = 8'hFF;
    foreach (exp_seq[i]) run_pkt(exp_seq[i], 9'd0, 1, 8'hFF, 0, 0, 0, nw);
  endtask

  task automatic test_reset_mid();
    int  nw;
    bit  got;
    wrr_en = 1'b1; ready = 1'b1; queue_nempty = 8'hFF;
    for (int i = 0; i < 3; i++) run_pkt(3'd7, 9'd0, 1, 8'hFF, 0, 0, 0, nw);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pop_vld) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL reset_mid_pop: no pop_vld within 40 cycles");
    end
    tick();
    fetch_vld = 1'b1; fetch_data = 16'h0183; fetch_last = 1'b0;
    tick();
    fetch_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    check_outputs_zero("reset_mid_packet");
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) run_pkt(3'd7, 9'd0, 1, 8'hFF, 0, 0, 0, nw);
    run_pkt(3'd6, 9'd1, 2, 8'h00, 0, 0, 0, nw);
    wrr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_strict();
    test_single_packet();
    test_gaps_ready_drop();
    test_len_err();
    test_wrr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
